div_unit: RTL

- Iterative M-extension divider for DIV, DIVU, REM and REMU.
- Sits in EX, parallel to the ALU. Its result feeds the writeback-select mux2X1 (a = ALU result, b = div_unit result).
- Hazard logic holds the pipeline while busy is high.
- Radix-2 restoring algorithm: one quotient bit per clock.

---
 rtl/div_unit_pkg.sv | 45 ++++
 rtl/div_step.sv | 34 +++
 rtl/div_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative M-extension divider.
// Carries the opcode and FSM-state encodings (`DIV_OP_*, `DIV_S_*), the
// register-width macro `REG_SIZE (reused if already defined), the FSM state
// type and small opcode-decode helpers used by div_unit and div_step.
// Optional build macro: DIV_EARLY_OUT_EN (consumed by div_unit).

`ifndef DIV_UNIT_DEFINES
`define DIV_UNIT_DEFINES

`ifndef REG_SIZE
`define REG_SIZE 31
`endif

`define DIV_OP_DIV  2'b00
`define DIV_OP_DIVU 2'b01
`define DIV_OP_REM  2'b10
`define DIV_OP_REMU 2'b11

`define DIV_S_IDLE 2'd0
`define DIV_S_CALC 2'd1
`define DIV_S_FIX  2'd2

`endif

package div_unit_pkg;

    localparam int unsigned DIV_OP_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = `DIV_S_IDLE,
        S_CALC = `DIV_S_CALC,
        S_FIX  = `DIV_S_FIX
    } div_state_t;

    // DIV and REM interpret operands as two's complement.
    function automatic logic is_signed_op(input logic [DIV_OP_W-1:0] op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder instead of the quotient.
    function automatic logic is_rem_op(input logic [DIV_OP_W-1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
// Ports:
//   rem      in  XLEN  partial remainder
//   quo      in  XLEN  dividend/quotient shift register
//   divisor  in  XLEN  divisor magnitude
//   rem_next out XLEN  updated partial remainder
//   quo_next out XLEN  quotient shifted left with the new bit in [0]

module div_step
    import div_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    // The shifted remainder keeps the bit pushed out of rem, so divisors with
    // the MSB set (unsigned) still compare correctly in XLEN+1 bits.
    logic [XLEN:0] rem_t;
    logic          ge;

    always_comb begin
        rem_t = {rem, quo[XLEN-1]};
        ge    = (rem_t >= {1'b0, divisor});
        // When ge holds the difference is below divisor, so XLEN bits suffice.
        rem_next = ge ? (rem_t[XLEN-1:0] - divisor) : rem_t[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], ge};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit
// per clock, sitting in EX beside the ALU.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request pulse, accepted only while busy=0
//   op     in   2-bit opcode (`DIV_OP_DIV/DIVU/REM/REMU)
//   rs1    in   dividend
//   rs2    in   divisor
//   flush  in   abort any in-flight operation
//   busy   out  high while CALC/FIX are in progress (registered)
//   done   out  one-cycle pulse, result valid
//   result out  quotient or remainder, held until the next done
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the
// iteration phase and complete one cycle after acceptance.

module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned XLEN  = `REG_SIZE + 1,
    parameter int unsigned CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [`REG_SIZE:0] rs1,
    input  logic [`REG_SIZE:0] rs2,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [`REG_SIZE:0] result
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t       state;
    logic [1:0]       op_q;
    logic             quo_neg_q;
    logic             rem_neg_q;
    logic             div_zero_q;
    logic             ovf_q;
    logic [XLEN-1:0]  rs1_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dvsr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [XLEN-1:0]  rem_next;
    logic [XLEN-1:0]  quo_next;

    // Request decode on the accepting edge.
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic             start_zero;
    logic             start_ovf;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;

    always_comb begin
        signed_op  = is_signed_op(op);
        a_neg      = signed_op & rs1[XLEN-1];
        b_neg      = signed_op & rs2[XLEN-1];
        a_mag      = a_neg ? (-rs1) : rs1;
        b_mag      = b_neg ? (-rs2) : rs2;
        start_zero = (rs2 == '0);
        start_ovf  = signed_op && (rs1 == INT_MIN) && (rs2 == '1);
    end

    // Sign correction and RISC-V special-case overrides for the final value.
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_val;

    always_comb begin
        quo_fix = quo_neg_q ? (-quo_q) : quo_q;
        rem_fix = rem_neg_q ? (-rem_q) : rem_q;
        if (div_zero_q) begin
            quo_fix = '1;
            rem_fix = rs1_q;
        end else if (ovf_q) begin
            quo_fix = INT_MIN;
            rem_fix = '0;
        end
        fix_val = is_rem_op(op_q) ? rem_fix : quo_fix;
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            op_q       <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            rs1_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            cnt_q      <= '0;
        end else if (flush) begin
            // Abort wins over everything, including a same-cycle start.
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q       <= op;
                        quo_neg_q  <= a_neg ^ b_neg;
                        rem_neg_q  <= a_neg;
                        div_zero_q <= start_zero;
                        ovf_q      <= start_ovf;
                        rs1_q      <= rs1;
                        quo_q      <= a_mag;
                        dvsr_q     <= b_mag;
                        rem_q      <= '0;
                        cnt_q      <= CNT_W'(XLEN - 1);
                        busy       <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        state      <= (start_zero || start_ovf) ? S_FIX : S_CALC;
`else
                        state      <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (cnt_q == '0) begin
                        state <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    result <= fix_val;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
